// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Owns the single regfile write port. Out of reset it sweeps zeros into
//   registers 1..REG_NUM-1 (the regfile storage has no reset), then
//   arbitrates round-robin between two write-back requesters.
//
// Ports
//   clk, rst               clock; synchronous active-low reset
//   a_valid/a_addr/a_data  port A (main pipeline WB) request
//   a_ready                port A accepted this cycle
//   b_valid/b_addr/b_data  port B (long-latency unit) request
//   b_ready                port B accepted this cycle
//   we/waddr/wdata         registered regfile write port
//   init_done              registered, high once the sweep has completed
//
// Handshake: a transfer happens on a posedge where valid && ready. The
// requester holds valid/addr/data stable until then, and valid never
// depends combinationally on ready. Ready is combinational from valid,
// state and last_grant, is never high without its valid, and at most one
// ready is high per cycle.
module regfile_wb_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              init_done
);

  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic {GRANT_A, GRANT_B} grant_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_NUM - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  state_t            state, state_next;
  grant_t            last_grant;
  logic [ADDR_W-1:0] sweep_addr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= INIT;
    else      state <= state_next;
  end

  // Next state and arbitration. Readies are forced low while rst is low
  // so nothing looks accepted during reset.
  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    case (state)
      INIT: begin
        if (sweep_addr == LAST_ADDR) state_next = RUN;
      end
      RUN: begin
        if (rst) begin
          // On a tie, the port that did not win last time gets it.
          a_ready = a_valid && (!b_valid || last_grant == GRANT_B);
          b_ready = b_valid && (!a_valid || last_grant == GRANT_A);
        end
      end
      default: state_next = INIT;
    endcase
  end

  // Registered write port, sweep counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      init_done  <= 1'b0;
      sweep_addr <= FIRST_ADDR;
      // Pretend B won last so A takes the first tie.
      last_grant <= GRANT_B;
    end else if (state == INIT) begin
      we         <= 1'b1;
      waddr      <= sweep_addr;
      wdata      <= '0;
      sweep_addr <= sweep_addr + FIRST_ADDR;
      // Rises together with the final sweep write being presented.
      if (sweep_addr == LAST_ADDR) init_done <= 1'b1;
    end else begin
      // No transfer: we drops, waddr/wdata keep their last values.
      we <= 1'b0;
      if (a_ready) begin
        last_grant <= GRANT_A;
        // Register 0 is hardwired; the request is accepted but dropped.
        if (a_addr != '0) begin
          we    <= 1'b1;
          waddr <= a_addr;
          wdata <= a_data;
        end
      end else if (b_ready) begin
        last_grant <= GRANT_B;
        if (b_addr != '0) begin
          we    <= 1'b1;
          waddr <= b_addr;
          wdata <= b_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int REG_NUM = 32;
  localparam int QW      = ADDR_W + DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic              we, init_done;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_NUM(REG_NUM)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .init_done(init_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behaviour expressed as: a count of sweep writes still owed, who won the
  // last tie, and the list of writes the regfile should see, in order.
  logic [QW-1:0] exp_q[$];
  bit            m_in_sweep;
  int            m_next_sweep;
  bit            m_b_won_last;
  bit            m_we, m_done, m_hold_known;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  bit            e_ra, e_rb, g_a, g_b;
  logic          s_ra, s_rb;

  task automatic model_reset();
    m_in_sweep   = 1'b1;
    m_next_sweep = 1;
    m_b_won_last = 1'b1;
    m_we = 1'b0; m_done = 1'b0; m_hold_known = 1'b1;
    m_waddr = '0; m_wdata = '0;
    exp_q.delete();
  endtask

  task automatic model_write(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
    m_we = 1'b1; m_waddr = ad; m_wdata = d; m_hold_known = 1'b1;
    exp_q.push_back({ad, d});
  endtask

  // One clock cycle: inputs must already be driven.
  task automatic step();
    @(negedge clk);
    e_ra = rst && !m_in_sweep && a_valid && (!b_valid || m_b_won_last);
    e_rb = rst && !m_in_sweep && b_valid && (!a_valid || !m_b_won_last);
    s_ra = a_ready; s_rb = b_ready;
    chk("a_ready", {63'd0, a_ready}, {63'd0, e_ra});
    chk("b_ready", {63'd0, b_ready}, {63'd0, e_rb});
    @(posedge clk);
    g_a = 1'b0; g_b = 1'b0;
    if (!rst) begin
      model_reset();
    end else if (m_in_sweep) begin
      model_write(ADDR_W'(m_next_sweep), '0);
      if (m_next_sweep == REG_NUM - 1) begin
        m_in_sweep = 1'b0;
        m_done = 1'b1;
      end
      m_next_sweep++;
    end else begin
      m_we = 1'b0;
      g_a = e_ra; g_b = e_rb;
      if (g_a || g_b) begin
        m_b_won_last = g_b;
        if (g_a && a_addr != 0) model_write(a_addr, a_data);
        else if (g_b && b_addr != 0) model_write(b_addr, b_data);
        else m_hold_known = 1'b0;   // address-0 write dropped
      end
    end
    #1;
    chk("we", {63'd0, we}, {63'd0, m_we});
    chk("init_done", {63'd0, init_done}, {63'd0, m_done});
    if (m_we) begin
      if (exp_q.size() == 0) chk("exp_q_empty", 64'd1, 64'd0);
      else chk("write", {27'd0, waddr, wdata}, {27'd0, exp_q.pop_front()});
    end else if (m_hold_known) begin
      chk("hold", {27'd0, waddr, wdata}, {27'd0, m_waddr, m_wdata});
    end
  endtask

  task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  // ---------------- directed vectors (after init, last grant = B) ----------------
  typedef struct {
    logic av; logic [ADDR_W-1:0] aa; logic [DATA_W-1:0] ad;
    logic bv; logic [ADDR_W-1:0] ba; logic [DATA_W-1:0] bd;
    logic era, erb, ewe, chk_pay;
    logic [ADDR_W-1:0] ewaddr; logic [DATA_W-1:0] ewdata;
  } vec_t;
  vec_t vecs[11];

  bit   pend_a, pend_b;

  initial begin
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 0, 1, 1, 5, 32'hDEADBEEF};
    vecs[1]  = '{0, 0, 0, 0, 0, 0,                 0, 0, 0, 1, 5, 32'hDEADBEEF};
    vecs[2]  = '{1, 3, 32'h11, 1, 4, 32'h22,       0, 1, 1, 1, 4, 32'h22};
    vecs[3]  = '{1, 3, 32'h11, 1, 4, 32'h22,       1, 0, 1, 1, 3, 32'h11};
    vecs[4]  = '{1, 3, 32'h11, 1, 4, 32'h22,       0, 1, 1, 1, 4, 32'h22};
    vecs[5]  = '{1, 3, 32'h11, 1, 4, 32'h22,       1, 0, 1, 1, 3, 32'h11};
    vecs[6]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,      1, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 3, 32'h11, 1, 4, 32'h22,       0, 1, 1, 1, 4, 32'h22};
    vecs[8]  = '{0, 0, 0, 1, 9, 32'h99,            0, 1, 1, 1, 9, 32'h99};
    vecs[9]  = '{0, 0, 0, 0, 0, 0,                 0, 0, 0, 1, 9, 32'h99};
    vecs[10] = '{1, 12, 32'hCAFE, 1, 12, 32'hF00D, 1, 0, 1, 1, 12, 32'hCAFE};

    model_reset();
    rst = 1'b0;
    drive(1, 2, 32'h1, 1, 3, 32'h2);   // valids during reset must not be accepted
    step(); step();
    chk("rst_waddr", {59'd0, waddr}, 64'd0);
    chk("rst_wdata", {32'd0, wdata}, 64'd0);

    // Sweep with no requests
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 1; i < REG_NUM; i++) begin
      step();
      chk("sweep_addr", {59'd0, waddr}, 64'(i));
      chk("sweep_done", {63'd0, init_done}, {63'd0, i == REG_NUM - 1});
    end
    step();
    chk("post_sweep_we", {63'd0, we}, 64'd0);

    // Table vectors
    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
      step();
      chk($sformatf("vec%0d_ra", i), {63'd0, s_ra}, {63'd0, vecs[i].era});
      chk($sformatf("vec%0d_rb", i), {63'd0, s_rb}, {63'd0, vecs[i].erb});
      chk($sformatf("vec%0d_we", i), {63'd0, we}, {63'd0, vecs[i].ewe});
      if (vecs[i].chk_pay)
        chk($sformatf("vec%0d_pay", i), {27'd0, waddr, wdata}, {27'd0, vecs[i].ewaddr, vecs[i].ewdata});
    end
    // Same address tie went to B last time? vec10 granted A; finish B's request.
    drive(0, 0, 0, 1, 12, 32'hF00D);
    step();
    chk("same_addr_final", {32'd0, wdata}, 64'hF00D);

    // Reset mid-RUN with a request pending, then B held through the re-sweep
    drive(1, 6, 32'h66, 0, 0, 0);
    rst = 1'b0;
    step();
    chk("midrst_we", {63'd0, we}, 64'd0);
    chk("midrst_done", {63'd0, init_done}, 64'd0);
    rst = 1'b1;
    drive(0, 0, 0, 1, 7, 32'h55);
    step();
    chk("resweep_first", {59'd0, waddr}, 64'd1);
    for (int i = 2; i < REG_NUM; i++) step();
    step();   // first RUN cycle: B accepted
    chk("held_b_ready", {63'd0, s_rb}, 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("held_b_write", {27'd0, waddr, wdata}, {27'd0, 5'd7, 32'h55});

    // Randomized traffic with occasional reset, protocol-respecting requesters
    pend_a = 1'b0; pend_b = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      if (!pend_a && $urandom_range(0, 2) != 0) begin
        pend_a = 1'b1; a_addr = ADDR_W'($urandom_range(0, REG_NUM - 1)); a_data = $urandom;
      end
      if (!pend_b && $urandom_range(0, 2) != 0) begin
        pend_b = 1'b1; b_addr = ADDR_W'($urandom_range(0, REG_NUM - 1)); b_data = $urandom;
      end
      a_valid = pend_a; b_valid = pend_b;
      step();
      if (g_a) pend_a = 1'b0;
      if (g_b) pend_b = 1'b0;
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single regfile write port (we/waddr/wdata).
- After reset, runs an init sweep that writes zero to registers 1..REG_NUM-1, because the regfile storage has no reset.
- After the sweep, it arbitrates between two write-back requesters over valid/ready handshakes:
  - Port A: main pipeline WB.
  - Port B: long-latency unit (mul/div/load miss).
- Sits between the WB stage and the regfile. The output is registered; the regfile's read-after-write bypass sees the write in the cycle it is presented.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- REG_NUM, 32, number of architectural registers; the sweep covers 1..REG_NUM-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 at posedge resets).
- a_valid  in  1  port A write request.
- a_addr  in  ADDR_W  port A destination register.
- a_data  in  DATA_W  port A write data.
- a_ready  out  1  port A request accepted this cycle.
- b_valid  in  1  port B write request.
- b_addr  in  ADDR_W  port B destination register.
- b_data  in  DATA_W  port B write data.
- b_ready  out  1  port B request accepted this cycle.
- we  out  1  regfile write enable (registered).
- waddr  out  ADDR_W  regfile write address (registered).
- wdata  out  DATA_W  regfile write data (registered).
- init_done  out  1  high once the sweep has completed (registered).

Behaviour:
- Reset (rst==0 at posedge):
  - Outputs: we=0, waddr=0, wdata=0, init_done=0.
  - State: state=INIT, sweep_addr=1, last_grant=B, so A wins the first tie.
  - a_ready=b_ready=0 while rst==0.
- State INIT:
  - Each cycle registers we=1, waddr=sweep_addr, wdata=0, then sweep_addr++.
  - The cycle that registers sweep_addr==REG_NUM-1 moves state to RUN.
  - init_done=1 is registered on that same edge, so it rises in the same cycle the final sweep write is presented (we=1, waddr=REG_NUM-1).
  - Exactly REG_NUM-1 sweep writes; register 0 is never written.
  - a_ready=b_ready=0 throughout INIT; requesters keep valid and payload held.
- State RUN, arbitration (combinational readies):
  - Only a_valid: a_ready=1.
  - Only b_valid: b_ready=1.
  - Both valid: grant the port != last_grant.
  - At most one ready is high per cycle; a ready is never high without its valid.
- Handshake:
  - Transfer occurs when valid && ready at a posedge.
  - The requester holds valid, addr and data stable until transfer.
  - valid must not depend combinationally on ready.
- On transfer:
  - Next cycle: we=1, waddr=granted addr, wdata=granted data.
  - last_grant updates to the granted port.
  - Latency is 1 cycle; throughput is 1 write per cycle.
- No transfer in a cycle: next cycle we=0; waddr and wdata hold their previous values.
- Address-0 request:
  - Accepted (ready=1), last_grant updated.
  - Next cycle we=0, so the write is dropped.
- Fairness: under continuous double request, grants alternate A,B,A,B; neither port waits more than 1 cycle.
- Same address from A and B in the same cycle: handled by normal arbitration; the later grant's data is the final value.
- Reset mid-INIT restarts the sweep at 1. Reset mid-RUN drops any registered-but-not-yet-presented write (we=0 next cycle) and re-runs INIT.
- No other states; RUN is left only via reset.

Test Plan:
- Sweep: release rst, no requests -> 31 consecutive cycles we=1 with waddr=1..31 and wdata=0; init_done rises in the same cycle as waddr=31; then we=0; a_ready=b_ready=0 during the sweep.
- Single port: after init, a_valid=1, a_addr=5, a_data=0xDEADBEEF for 1 cycle -> a_ready=1 that cycle; next cycle we=1, waddr=5, wdata=0xDEADBEEF; the following cycle we=0.
- Round-robin: A (addr 3, 0x11) and B (addr 4, 0x22) held valid, each reissuing after transfer -> grants A,B,A,B; waddr sequence 3,4,3,4 on consecutive cycles.
- Held during INIT: b_valid=1, b_addr=7, b_data=0x55 asserted from rst release -> b_ready=0 until RUN; first RUN cycle b_ready=1; next cycle waddr=7, wdata=0x55.
- Zero address: a_valid=1, a_addr=0, a_data=0xFFFFFFFF -> a_ready=1, we stays 0; last_grant=A, so a following simultaneous A/B request grants B.
- Reset mid-operation: rst=0 for 1 cycle during RUN with a transfer in flight -> we=0 next cycle, init_done=0, sweep restarts at waddr=1.
